// File: rtl/db_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : db_arb_if
//  Purpose  : Bundles the requester, response and engine-side signals of the
//             db_arb two-port arbiter. Packed per-port buses hold port 1 in
//             the upper half.
//  Revision : 1.0  initial release
// ============================================================================
interface db_arb_if #(
    parameter int HASH_SIZE = 32,
    parameter int KEY_SIZE  = 96,
    parameter int VAL_SIZE  = 32
);
    // requester side
    logic [1:0]              req_valid;
    logic [1:0]              req_ready;
    logic [7:0]              req_op;
    logic [2*HASH_SIZE-1:0]  req_hash;
    logic [2*KEY_SIZE-1:0]   req_key;
    logic [2*VAL_SIZE-1:0]   req_value;
    logic [1:0]              rsp_valid;
    logic                    rsp_hit;
    logic [3:0]              rsp_flag;
    // engine side
    logic                    db_valid;
    logic [3:0]              db_op;
    logic [HASH_SIZE-1:0]    db_hash;
    logic [KEY_SIZE-1:0]     db_key;
    logic [VAL_SIZE-1:0]     db_value;
    logic                    db_out_valid;
    logic [3:0]              db_out_flag;
    // statistics
    logic [31:0]             stat_hit_cnt;
    logic [31:0]             stat_miss_cnt;

    // arbiter side
    modport slave (
        input  req_valid, req_op, req_hash, req_key, req_value,
        input  db_out_valid, db_out_flag,
        output req_ready, rsp_valid, rsp_hit, rsp_flag,
        output db_valid, db_op, db_hash, db_key, db_value,
        output stat_hit_cnt, stat_miss_cnt
    );

    // requesters and engine side
    modport master (
        output req_valid, req_op, req_hash, req_key, req_value,
        output db_out_valid, db_out_flag,
        input  req_ready, rsp_valid, rsp_hit, rsp_flag,
        input  db_valid, db_op, db_hash, db_key, db_value,
        input  stat_hit_cnt, stat_miss_cnt
    );
endinterface
`default_nettype wire

// File: rtl/db_arb.sv
`default_nettype none
// ============================================================================
//  Module   : db_arb
//  Purpose  : Two-port round-robin arbiter and slot sequencer in front of the
//             db_cont lookup engine. Each accepted request occupies a fixed
//             slot of SLOT_CYCLES+3 cycles; absence of an engine strobe in the
//             slot is reported as a miss to the issuing port.
//  Options  : DB_ARB_STATS_EN - builds 32-bit hit/miss counters; otherwise the
//             stat outputs are tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module db_arb #(
    parameter int HASH_SIZE   = 32,
    parameter int KEY_SIZE    = 96,
    parameter int VAL_SIZE    = 32,
    parameter int SLOT_CYCLES = 4
) (
    input  wire logic  clk,
    input  wire logic  rst,     // asynchronous, active-low
    db_arb_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] c_cnt_load = 4'(SLOT_CYCLES - 1);

    state_t                r_state;
    logic                  r_last_grant;
    logic                  r_grant;
    logic [3:0]            r_cnt;
    logic                  r_hit;
    logic [3:0]            r_flag;
    logic                  r_db_valid;
    logic [3:0]            r_op;
    logic [HASH_SIZE-1:0]  r_hash;
    logic [KEY_SIZE-1:0]   r_key;
    logic [VAL_SIZE-1:0]   r_value;
    logic [1:0]            r_rsp_valid;
    logic                  r_rsp_hit;
    logic [3:0]            r_rsp_flag;

    logic                  w_grant;
    logic                  w_accept;
    logic [1:0]            w_req_ready;
    logic [3:0]            w_sel_op;
    logic [HASH_SIZE-1:0]  w_sel_hash;
    logic [KEY_SIZE-1:0]   w_sel_key;
    logic [VAL_SIZE-1:0]   w_sel_value;

    // Round-robin grant selection and field mux of the granted port; nothing
    // is accepted while reset is held.
    always_comb begin
        w_grant = r_last_grant;
        case (bus.req_valid)
            2'b01:   w_grant = 1'b0;
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = ~r_last_grant;
            default: w_grant = r_last_grant;
        endcase
        w_accept    = (r_state == S_IDLE) && rst && (bus.req_valid != 2'b00);
        w_req_ready = 2'b00;
        if (w_accept) begin
            w_req_ready[w_grant] = 1'b1;
        end
        w_sel_op    = w_grant ? bus.req_op[7:4] : bus.req_op[3:0];
        w_sel_hash  = w_grant ? bus.req_hash[2*HASH_SIZE-1:HASH_SIZE] : bus.req_hash[HASH_SIZE-1:0];
        w_sel_key   = w_grant ? bus.req_key[2*KEY_SIZE-1:KEY_SIZE]    : bus.req_key[KEY_SIZE-1:0];
        w_sel_value = w_grant ? bus.req_value[2*VAL_SIZE-1:VAL_SIZE]  : bus.req_value[VAL_SIZE-1:0];
    end

    // Slot sequencer: accept, issue strobe, timed wait with first-hit capture,
    // one-cycle response to the granted port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_cnt        <= 4'd0;
            r_hit        <= 1'b0;
            r_flag       <= 4'd0;
            r_db_valid   <= 1'b0;
            r_op         <= 4'd0;
            r_hash       <= '0;
            r_key        <= '0;
            r_value      <= '0;
            r_rsp_valid  <= 2'b00;
            r_rsp_hit    <= 1'b0;
            r_rsp_flag   <= 4'd0;
        end else begin
            r_db_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op         <= w_sel_op;
                        r_hash       <= w_sel_hash;
                        r_key        <= w_sel_key;
                        r_value      <= w_sel_value;
                        r_grant      <= w_grant;
                        r_last_grant <= w_grant;
                        r_hit        <= 1'b0;
                        r_flag       <= 4'd0;
                        r_db_valid   <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= c_cnt_load;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // only the first engine strobe of a slot is kept
                    if (bus.db_out_valid && !r_hit) begin
                        r_hit  <= 1'b1;
                        r_flag <= bus.db_out_flag;
                    end
                    if (r_cnt == 4'd0) begin
                        // response is prepared here so it leaves a register;
                        // a strobe on this last wait cycle still counts
                        r_state     <= S_RESP;
                        r_rsp_valid <= r_grant ? 2'b10 : 2'b01;
                        r_rsp_hit   <= r_hit | bus.db_out_valid;
                        r_rsp_flag  <= r_hit ? r_flag :
                                       (bus.db_out_valid ? bus.db_out_flag : 4'd0);
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= 2'b00;
                    r_rsp_hit   <= 1'b0;
                    r_rsp_flag  <= 4'd0;
                    r_hit       <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_hit   = r_rsp_hit;
    assign bus.rsp_flag  = r_rsp_flag;
    assign bus.db_valid  = r_db_valid;
    assign bus.db_op     = r_op;
    assign bus.db_hash   = r_hash;
    assign bus.db_key    = r_key;
    assign bus.db_value  = r_value;

`ifdef DB_ARB_STATS_EN
    logic [31:0] r_stat_hit;
    logic [31:0] r_stat_miss;

    // Count each delivered response as a hit or a miss; counters wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_hit  <= 32'd0;
            r_stat_miss <= 32'd0;
        end else if (r_state == S_RESP) begin
            if (r_rsp_hit) begin
                r_stat_hit <= r_stat_hit + 32'd1;
            end else begin
                r_stat_miss <= r_stat_miss + 32'd1;
            end
        end
    end

    assign bus.stat_hit_cnt  = r_stat_hit;
    assign bus.stat_miss_cnt = r_stat_miss;
`else
    assign bus.stat_hit_cnt  = 32'd0;
    assign bus.stat_miss_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_db_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_db_arb
//  Purpose  : Self-checking bench for db_arb with a behavioural lookup engine
//             and a response scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_db_arb;

    localparam int HS   = 32;
    localparam int KS   = 96;
    localparam int VS   = 32;
    localparam int SLOT = 4;

    localparam logic [KS-1:0] KEY_A  = 96'hA0A0_0000_1111_2222_3333_4444;
    localparam logic [KS-1:0] KEY_B  = 96'hB0B0_5555_6666_7777_8888_9999;
    localparam logic [KS-1:0] KEY_C  = 96'hC0C0_DEAD_BEEF_0123_4567_89AB;
    localparam logic [KS-1:0] KEY_D  = 96'hD0D0_FEED_FACE_CAFE_0000_0001;
    localparam logic [HS-1:0] HASH_A = 32'h1234_00AA;
    localparam logic [HS-1:0] HASH_B = 32'h5678_00BB;
    localparam logic [HS-1:0] HASH_C = 32'h9ABC_00CC;
    localparam logic [HS-1:0] HASH_D = 32'hDEF0_00DD;
    localparam logic [3:0]    FLAG_A = 4'b0100;
    localparam logic [3:0]    FLAG_B = 4'b1010;
    localparam logic [VS-1:0] VAL_B  = {28'h0ABCDEF, FLAG_B};
    localparam logic [3:0]    OP_GET = 4'h0;
    localparam logic [3:0]    OP_SET = 4'h1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    db_arb_if #(.HASH_SIZE(HS), .KEY_SIZE(KS), .VAL_SIZE(VS)) bus ();

    db_arb #(
        .HASH_SIZE  (HS),
        .KEY_SIZE   (KS),
        .VAL_SIZE   (VS),
        .SLOT_CYCLES(SLOT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       port;
        logic       hit;
        logic [3:0] flag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   grant_log[$];
    int   acc_log[$];
    int   acc_cyc   = 0;
    int   exp_hits  = 0;
    int   exp_miss  = 0;

    logic [3:0] tbl [logic [KS-1:0]];

    logic       eng_ov = 1'b0, tb_ov = 1'b0;
    logic [3:0] eng_flag = 4'd0, tb_flag = 4'd0;
    assign bus.db_out_valid = eng_ov | tb_ov;
    assign bus.db_out_flag  = eng_flag | tb_flag;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic p, input logic h, input logic [3:0] f);
        exp_t e;
        e.port = p;
        e.hit  = h;
        e.flag = f;
        exp_q.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input int port, input logic [3:0] op, input logic [HS-1:0] h,
                         input logic [KS-1:0] k, input logic [VS-1:0] v);
        int  t;
        bit  got;
        t   = 0;
        got = 1'b0;
        bus.req_op[port*4 +: 4]     = op;
        bus.req_hash[port*HS +: HS] = h;
        bus.req_key[port*KS +: KS]  = k;
        bus.req_value[port*VS +: VS] = v;
        bus.req_valid[port]         = 1'b1;
        while (!got && t < 60) begin
            @(negedge clk);
            t++;
            if (bus.req_ready[port]) got = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.req_valid[port] = 1'b0;
        chk("accept", got, 1'b1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Behavioural engine: looks up on the strobe, answers two cycles later on
    // a hit, and checks the request fields stay put through the wait window.
    logic [3:0]    e_op;
    logic [HS-1:0] e_hash;
    logic [KS-1:0] e_key;
    logic [VS-1:0] e_val;
    logic          e_hit;
    logic [3:0]    e_flag;
    logic          e_abort;
    always @(negedge clk) begin
        if (rst && bus.db_valid) begin
            e_op    = bus.db_op;
            e_hash  = bus.db_hash;
            e_key   = bus.db_key;
            e_val   = bus.db_value;
            e_hit   = tbl.exists(e_key) ? 1'b1 : 1'b0;
            e_flag  = e_hit ? tbl[e_key] : 4'd0;
            if (e_op[0]) tbl[e_key] = e_val[3:0];
            chk("db_valid_time", cyc, acc_cyc + 1);
            e_abort = 1'b0;
            for (int i = 1; i <= SLOT; i++) begin
                @(negedge clk);
                if (!rst) e_abort = 1'b1;
                if (!e_abort) begin
                    chk("db_valid_one_cycle", bus.db_valid, 1'b0);
                    chk("db_key_hold",   bus.db_key,   e_key);
                    chk("db_hash_hold",  bus.db_hash,  e_hash);
                    chk("db_op_hold",    bus.db_op,    e_op);
                    chk("db_value_hold", bus.db_value, e_val);
                end
                if (i == 2 && e_hit && !e_abort) begin
                    eng_ov   = 1'b1;
                    eng_flag = e_flag;
                end
                if (i == 3) begin
                    eng_ov   = 1'b0;
                    eng_flag = 4'd0;
                end
            end
        end
    end

    // Accept logging and response scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.req_ready != 2'b00) begin
                acc_cyc = cyc;
                grant_log.push_back(int'(bus.req_ready[1]));
                acc_log.push_back(cyc);
                chk("ready_onehot", (bus.req_ready == 2'b11), 1'b0);
                chk("ready_needs_valid", bus.req_ready & ~bus.req_valid, 2'b00);
            end
            if (bus.rsp_valid != 2'b00) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_rsp", bus.rsp_valid, 2'b00);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_port", bus.rsp_valid, mon_e.port ? 2'b10 : 2'b01);
                    chk("rsp_hit",  bus.rsp_hit,  mon_e.hit);
                    chk("rsp_flag", bus.rsp_flag, mon_e.flag);
                    chk("rsp_time", cyc, acc_cyc + 2 + SLOT);
                    if (mon_e.hit) exp_hits++;
                    else           exp_miss++;
                end
            end
        end
    end

    initial begin
        int cnt;
        int t;
        tbl[KEY_A]    = FLAG_A;
        bus.req_valid = 2'b00;
        bus.req_op    = '0;
        bus.req_hash  = '0;
        bus.req_key   = '0;
        bus.req_value = '0;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 2'b00);
        chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
        chk("rst_rsp_hit",   bus.rsp_hit,   1'b0);
        chk("rst_rsp_flag",  bus.rsp_flag,  4'd0);
        chk("rst_db_valid",  bus.db_valid,  1'b0);
        chk("rst_db_key",    bus.db_key,    '0);
        chk("rst_db_hash",   bus.db_hash,   '0);
        chk("rst_stat_hit",  bus.stat_hit_cnt,  32'd0);
        chk("rst_stat_miss", bus.stat_miss_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // both ports contending for four slots: 0,1,0,1 at 7-cycle spacing
        grant_log.delete();
        acc_log.delete();
        push_exp(1'b0, 1'b1, FLAG_A);
        push_exp(1'b1, 1'b0, 4'd0);
        push_exp(1'b0, 1'b1, FLAG_A);
        push_exp(1'b1, 1'b0, 4'd0);
        bus.req_op    = {OP_GET, OP_GET};
        bus.req_hash  = {HASH_C, HASH_A};
        bus.req_key   = {KEY_C, KEY_A};
        bus.req_valid = 2'b11;
        cnt = 0;
        t   = 0;
        while (cnt < 4 && t < 100) begin
            @(negedge clk);
            t++;
            if (bus.req_ready != 2'b00) cnt++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        chk("rr_accepts", cnt, 4);
        drain();
        chk("rr_log_size", grant_log.size(), 4);
        for (int k = 0; k < grant_log.size() && k < 4; k++) begin
            chk("rr_order", grant_log[k], k % 2);
            if (k > 0) chk("rr_spacing", acc_log[k] - acc_log[k-1], SLOT + 3);
        end

        // port 0 GET of a present key
        push_exp(1'b0, 1'b1, FLAG_A);
        issue(0, OP_GET, HASH_A, KEY_A, '0);
        drain();

        // port 1 SET of an absent key, then GET of that key from port 0
        push_exp(1'b1, 1'b0, 4'd0);
        issue(1, OP_SET, HASH_B, KEY_B, VAL_B);
        drain();
        push_exp(1'b0, 1'b1, FLAG_B);
        issue(0, OP_GET, HASH_B, KEY_B, '0);
        drain();

        // reset in the middle of WAIT drops the slot
        issue(0, OP_GET, HASH_C, KEY_C, '0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_rsp_valid", bus.rsp_valid, 2'b00);
        chk("midrst_db_valid",  bus.db_valid,  1'b0);
        chk("midrst_db_key",    bus.db_key,    '0);
        @(negedge clk);
        chk("midrst_rsp_valid_next", bus.rsp_valid, 2'b00);
        chk("midrst_db_valid_next",  bus.db_valid,  1'b0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        exp_q.delete();
        exp_hits = 0;
        exp_miss = 0;
        repeat (4) @(posedge clk);
        #1;
        push_exp(1'b1, 1'b1, FLAG_A);
        issue(1, OP_GET, HASH_A, KEY_A, '0);
        drain();

        // stray engine strobe while idle produces nothing and is not kept
        tb_ov   = 1'b1;
        tb_flag = 4'hF;
        @(posedge clk);
        #1;
        tb_ov   = 1'b0;
        tb_flag = 4'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("idle_no_rsp", bus.rsp_valid, 2'b00);
        end
        @(posedge clk);
        #1;
        push_exp(1'b0, 1'b0, 4'd0);
        issue(0, OP_GET, HASH_C, KEY_C, '0);
        drain();

        // fill out three hits and two misses since the last reset
        push_exp(1'b0, 1'b1, FLAG_A);
        issue(0, OP_GET, HASH_A, KEY_A, '0);
        drain();
        push_exp(1'b1, 1'b1, FLAG_B);
        issue(1, OP_GET, HASH_B, KEY_B, '0);
        drain();
        push_exp(1'b1, 1'b0, 4'd0);
        issue(1, OP_GET, HASH_D, KEY_D, '0);
        drain();

        @(negedge clk);
`ifdef DB_ARB_STATS_EN
        chk("stat_hit",  bus.stat_hit_cnt,  32'd3);
        chk("stat_miss", bus.stat_miss_cnt, 32'd2);
        chk("stat_hit_sb",  bus.stat_hit_cnt,  exp_hits);
        chk("stat_miss_sb", bus.stat_miss_cnt, exp_miss);
`else
        chk("stat_hit_off",  bus.stat_hit_cnt,  32'd0);
        chk("stat_miss_off", bus.stat_miss_cnt, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/db_arb.md
# db_arb

Two-port round-robin arbiter and sequencer placed in front of the `db_cont` key/value lookup engine. `db_cont` has no ready signal, needs several cycles per request, and only asserts `out_valid` on a key hit. This block does four things:
- serialises requests from two requesters into fixed-length slots;
- holds the request fields stable for the whole slot;
- turns "no `out_valid` within the slot" into an explicit miss response;
- routes each response back to the requester that issued it.

## Interface
Parameters:
- `HASH_SIZE`, 32, hash width per request
- `KEY_SIZE`, 96, key width per request
- `VAL_SIZE`, 32, value width per request
- `SLOT_CYCLES`, 4, wait cycles after issue; legal range 3..15

Ports (index i = requester 0/1; packed buses hold port 1 in the upper half):
- `clk`  in  1  single clock for all logic
- `rst`  in  1  reset, asynchronous, active-low
- `req_valid`  in  2  request present, per port
- `req_ready`  out  2  request accepted this cycle, per port
- `req_op`  in  8  4-bit op per port; bit0=1 SET, bit0=0 GET
- `req_hash`  in  2*HASH_SIZE  hash per port
- `req_key`  in  2*KEY_SIZE  key per port
- `req_value`  in  2*VAL_SIZE  value per port
- `rsp_valid`  out  2  one-cycle response pulse, per port
- `rsp_hit`  out  1  1 = engine reported a hit
- `rsp_flag`  out  4  flag captured from the engine; 0 on miss
- `db_valid`  out  1  request strobe to the engine
- `db_op`  out  4  op to the engine
- `db_hash`  out  HASH_SIZE  hash to the engine
- `db_key`  out  KEY_SIZE  key to the engine
- `db_value`  out  VAL_SIZE  value to the engine
- `db_out_valid`  in  1  engine result strobe
- `db_out_flag`  in  4  engine result flag
- `stat_hit_cnt`  out  32  hit counter, see Configuration
- `stat_miss_cnt`  out  32  miss counter, see Configuration

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - Grant goes to the single valid port.
  - If both ports are valid, grant goes to the port not in `last_grant`.
  - `req_ready[g] = (state==IDLE) & req_valid[g]` (combinational). At most one bit is high.
  - On accept: latch op/hash/key/value into hold registers, set `last_grant <= g`, go to ISSUE.
- ISSUE: `db_valid=1` for exactly one cycle. Load the wait counter with `SLOT_CYCLES-1`. Go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - The first `db_out_valid` seen sets `hit=1` and captures `db_out_flag`. Later strobes in the same slot are ignored.
  - When the counter reaches 0, go to RESP.
- RESP: `rsp_valid[g]=1` for one cycle, with `rsp_hit=hit` and `rsp_flag=hit ? captured flag : 0`. Clear `hit`. Go to IDLE.
- `db_op`, `db_hash`, `db_key` and `db_value` come from the hold registers. They are stable from ISSUE through the last WAIT cycle, because the engine samples them in every internal state, including its table-write cycle.
- `db_out_valid` seen in IDLE, ISSUE or RESP is discarded.
- Requesters must not make `req_valid` depend on `req_ready`. A requester that is not granted keeps its request pending.

## Timing
- Reset values: `req_ready=0`, `rsp_valid=0`, `rsp_hit=0`, `rsp_flag=0`, `db_valid=0`, `db_*` fields 0, `last_grant=1` (port 0 wins the first tie), stat counters 0, state IDLE.
- Request accepted at cycle T:
  - `db_valid` high at T+1.
  - WAIT occupies T+2..T+1+SLOT_CYCLES.
  - `rsp_valid` high at T+2+SLOT_CYCLES.
  - Next accept no earlier than T+3+SLOT_CYCLES.
- Throughput is one request per `SLOT_CYCLES+3` cycles.
- An engine hit asserts `out_valid` at T+3, which falls inside the window for every legal `SLOT_CYCLES`.
- Asserting reset mid-slot (asynchronous): FSM returns to IDLE, `db_valid` and `rsp_valid` drop immediately, the in-flight request is lost with no response, and `last_grant=1`.

## Configuration
- `DB_ARB_STATS_EN` defined:
  - `stat_hit_cnt` increments in RESP when `hit=1`.
  - `stat_miss_cnt` increments in RESP when `hit=0`.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and are cleared by reset.
- Not defined: both stat ports are tied to 0 and no counter logic is built.

## Test plan
- Port 0 GET, key present with flag 4'b0100, `SLOT_CYCLES=4`, accept at T → `db_valid` at T+1; `rsp_valid[0]` at T+6 with `rsp_hit=1`, `rsp_flag=4'b0100`.
- Port 1 SET, key absent → `rsp_valid[1]` with `rsp_hit=0`, `rsp_flag=0`; `db_key`/`db_hash` held constant T+1..T+5; a subsequent GET of the same key returns `rsp_hit=1`.
- Both ports valid continuously for 4 slots after reset → grants in order 0,1,0,1; each accept is 7 cycles after the previous one.
- Reset asserted during WAIT → next cycle: no `rsp_valid`, `db_valid=0`. After release, a port 1 request is served first, and its response is correct.
- `db_out_valid` pulsed while in IDLE with no request → no `rsp_valid`. With `DB_ARB_STATS_EN`: 3 hits and 2 misses → `stat_hit_cnt=3`, `stat_miss_cnt=2`.
